// File: rtl/dcache_ctrl_pkg.sv
// Shared types for the data-cache controller: bus command encodings, memory-tag
// sizing, cache line, return-queue entry and miss-table entry layouts.
package dcache_ctrl_pkg;

  typedef enum logic [1:0] {
    BUS_NONE  = 2'h0,
    BUS_LOAD  = 2'h1,
    BUS_STORE = 2'h2
  } bus_cmd_t;

  localparam int NUM_MEM_TAG_BITS = 4;
  localparam int NUM_MEM_TAGS     = 15;
  // 64-bit address minus the byte offset; wide enough for any SETS.
  localparam int BLK_W            = 61;

  typedef logic [NUM_MEM_TAG_BITS-1:0] mem_tag_t;

  typedef struct packed {
    logic             valid;
    logic [BLK_W-1:0] tag;
    logic [63:0]      data;
  } line_t;

  typedef struct packed {
    mem_tag_t    tag;
    logic [63:0] data;
  } ret_entry_t;

  typedef struct packed {
    logic             pend;
    logic             fill_ok;
    logic [BLK_W-1:0] addr;
  } miss_entry_t;

endpackage

// File: rtl/dcache_ctrl_if.sv
// LSQ-side and memory-side signal bundle of the data-cache controller.
// slave = controller, master = LSQ/memory environment.
interface dcache_ctrl_if;
  import dcache_ctrl_pkg::*;

  bus_cmd_t    lsq2mem_command;
  logic [63:0] lsq2mem_addr;
  logic [63:0] lsq2mem_data;
  mem_tag_t    mem2lsq_response;
  logic        dcache2lsq_valid;
  mem_tag_t    dcache2lsq_tag;
  logic [63:0] dcache2lsq_data;
  logic        dcache2lsq_st_received;
  bus_cmd_t    proc2mem_command;
  logic [63:0] proc2mem_addr;
  logic [63:0] proc2mem_data;
  mem_tag_t    mem2proc_response;
  logic [63:0] mem2proc_data;
  mem_tag_t    mem2proc_tag;

  modport slave (
    input  lsq2mem_command, lsq2mem_addr, lsq2mem_data,
    input  mem2proc_response, mem2proc_data, mem2proc_tag,
    output mem2lsq_response, dcache2lsq_valid, dcache2lsq_tag, dcache2lsq_data,
    output dcache2lsq_st_received, proc2mem_command, proc2mem_addr, proc2mem_data
  );

  modport master (
    output lsq2mem_command, lsq2mem_addr, lsq2mem_data,
    output mem2proc_response, mem2proc_data, mem2proc_tag,
    input  mem2lsq_response, dcache2lsq_valid, dcache2lsq_tag, dcache2lsq_data,
    input  dcache2lsq_st_received, proc2mem_command, proc2mem_addr, proc2mem_data
  );

endinterface

// File: rtl/dcache_retq.sv
// Return-data FIFO with a head-valid flag; push and pop may occur in the same
// cycle, and a push into a full queue is accepted only alongside a pop.
module dcache_retq #(
  parameter int DEPTH = 4,
  parameter int W     = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] din_i,
  input  logic         pop_i,
  output logic [W-1:0] dout_o,
  output logic         head_valid_o,
  output logic         full_o
);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             do_push, do_pop;

  assign head_valid_o = (cnt_q != '0);
  assign full_o       = (cnt_q == CNT_W'(DEPTH));
  assign dout_o       = mem_q[rd_ptr_q];
  assign do_pop       = pop_i && head_valid_o;
  assign do_push      = push_i && (!full_o || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (do_pop)
      rd_ptr_d = (rd_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : rd_ptr_q + PTR_W'(1);
    if (do_push)
      wr_ptr_d = (wr_ptr_q == PTR_W'(DEPTH - 1)) ? '0 : wr_ptr_q + PTR_W'(1);
    cnt_d = cnt_q + CNT_W'(do_push) - CNT_W'(do_pop);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= din_i;
  end

endmodule

// File: rtl/dcache_ctrl.sv
// Direct-mapped, write-through, no-write-allocate data-cache controller between
// the LSQ and memory. Optional hit/miss counters are enabled by DCACHE_STATS_EN.
module dcache_ctrl
  import dcache_ctrl_pkg::*;
#(
  parameter int SETS     = 32,
  parameter int RQ_DEPTH = 4
) (
  input  logic          clk,
  input  logic          reset,
  dcache_ctrl_if.slave  bus
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]   dcache_hit_cnt,
  output logic [31:0]   dcache_miss_cnt
`endif
);
  localparam int IDX_W = $clog2(SETS);
  localparam int OMC_W = $clog2(RQ_DEPTH + 1);

  line_t       lines_q [SETS];
  miss_entry_t mtab_q  [NUM_MEM_TAGS+1];
  logic [OMC_W-1:0] omc_q, omc_d;

  logic [BLK_W-1:0] req_blk, req_tag, ret_tag;
  logic [IDX_W-1:0] req_idx, ret_idx;
  logic is_load, is_store, hit, deliver, load_hit, miss_fwd, miss_acc;
  logic st_write, ret_push, fill_en, q_head_valid, q_full;
  miss_entry_t ret_ent;
  ret_entry_t  q_head;
  logic [$bits(ret_entry_t)-1:0] q_dout;

  assign req_blk  = bus.lsq2mem_addr[63:3];
  assign req_idx  = req_blk[IDX_W-1:0];
  assign req_tag  = req_blk >> IDX_W;
  assign is_load  = (bus.lsq2mem_command == BUS_LOAD);
  assign is_store = (bus.lsq2mem_command == BUS_STORE);
  assign hit      = lines_q[req_idx].valid && (lines_q[req_idx].tag == req_tag);

  assign deliver  = !is_store && q_head_valid;
  assign load_hit = is_load && !q_head_valid && hit;
  assign miss_fwd = is_load && !q_head_valid && !hit && (omc_q < OMC_W'(RQ_DEPTH));
  assign miss_acc = miss_fwd && (bus.mem2proc_response != '0);
  assign st_write = is_store && (bus.mem2proc_response != '0) && hit;

  // Returns for tags not issued since reset have no pending entry and are dropped.
  assign ret_ent  = mtab_q[bus.mem2proc_tag];
  assign ret_push = (bus.mem2proc_tag != '0) && ret_ent.pend;
  assign ret_idx  = ret_ent.addr[IDX_W-1:0];
  assign ret_tag  = ret_ent.addr >> IDX_W;
  // A same-cycle store to the block or to the line being filled takes precedence.
  assign fill_en  = ret_push && ret_ent.fill_ok
                    && !(is_store && (ret_ent.addr == req_blk))
                    && !(st_write && (ret_idx == req_idx));

  assign q_head = ret_entry_t'(q_dout);
  assign omc_d  = omc_q + OMC_W'(miss_acc) - OMC_W'(deliver);

  dcache_retq #(
    .DEPTH (RQ_DEPTH),
    .W     ($bits(ret_entry_t))
  ) u_retq (
    .clk          (clk),
    .reset        (reset),
    .push_i       (ret_push),
    .din_i        ({bus.mem2proc_tag, bus.mem2proc_data}),
    .pop_i        (deliver),
    .dout_o       (q_dout),
    .head_valid_o (q_head_valid),
    .full_o       (q_full)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int s = 0; s < SETS; s++) lines_q[s] <= '0;
      for (int t = 0; t <= NUM_MEM_TAGS; t++) mtab_q[t] <= '0;
      omc_q <= '0;
    end else begin
      omc_q <= omc_d;
      if (fill_en) lines_q[ret_idx] <= '{valid: 1'b1, tag: ret_tag, data: bus.mem2proc_data};
      if (st_write) lines_q[req_idx].data <= bus.lsq2mem_data;
      for (int t = 1; t <= NUM_MEM_TAGS; t++)
        if (is_store && (mtab_q[t].addr == req_blk)) mtab_q[t].fill_ok <= 1'b0;
      if (ret_push) mtab_q[bus.mem2proc_tag] <= '0;
      if (miss_acc) mtab_q[bus.mem2proc_response] <= '{pend: 1'b1, fill_ok: 1'b1, addr: req_blk};
    end
  end

  always_comb begin
    bus.mem2lsq_response       = '0;
    bus.dcache2lsq_valid       = 1'b0;
    bus.dcache2lsq_tag         = '0;
    bus.dcache2lsq_data        = '0;
    bus.dcache2lsq_st_received = 1'b0;
    bus.proc2mem_command       = BUS_NONE;
    bus.proc2mem_addr          = '0;
    bus.proc2mem_data          = '0;
    if (!reset) begin
      bus.proc2mem_addr = bus.lsq2mem_addr;
      if (is_store) begin
        bus.proc2mem_command       = BUS_STORE;
        bus.proc2mem_data          = bus.lsq2mem_data;
        bus.dcache2lsq_st_received = 1'b1;
        bus.dcache2lsq_tag         = bus.mem2proc_response;
      end else if (deliver) begin
        bus.dcache2lsq_valid = 1'b1;
        bus.dcache2lsq_tag   = q_head.tag;
        bus.dcache2lsq_data  = q_head.data;
      end else if (load_hit) begin
        bus.dcache2lsq_valid = 1'b1;
        bus.dcache2lsq_data  = lines_q[req_idx].data;
      end else if (miss_fwd) begin
        bus.proc2mem_command = BUS_LOAD;
        bus.mem2lsq_response = bus.mem2proc_response;
      end
    end
  end

  assert property (@(posedge clk) disable iff (reset) !((bus.mem2proc_tag != '0) && q_full));

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt_q, miss_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hit_cnt_q  <= '0;
      miss_cnt_q <= '0;
    end else begin
      if (load_hit && (hit_cnt_q != '1))  hit_cnt_q  <= hit_cnt_q + 32'd1;
      if (miss_acc && (miss_cnt_q != '1)) miss_cnt_q <= miss_cnt_q + 32'd1;
    end
  end

  assign dcache_hit_cnt  = hit_cnt_q;
  assign dcache_miss_cnt = miss_cnt_q;
`endif

endmodule

// File: tb/tb_dcache_ctrl.sv
// Directed-vector bench for dcache_ctrl (SETS=32, RQ_DEPTH=4); one task per scenario.
module tb_dcache_ctrl;
  import dcache_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  dcache_ctrl_if bus ();

`ifdef DCACHE_STATS_EN
  logic [31:0] hit_cnt, miss_cnt;
`endif

  dcache_ctrl #(.SETS(32), .RQ_DEPTH(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef DCACHE_STATS_EN
    ,
    .dcache_hit_cnt  (hit_cnt),
    .dcache_miss_cnt (miss_cnt)
`endif
  );

  logic [68:0] rsp;
  logic [5:0]  memreq;
  logic [4:0]  st_ack;
  assign rsp    = {bus.dcache2lsq_valid, bus.dcache2lsq_tag, bus.dcache2lsq_data};
  assign memreq = {bus.proc2mem_command, bus.mem2lsq_response};
  assign st_ack = {bus.dcache2lsq_st_received, bus.dcache2lsq_tag};

  task automatic drive(input bus_cmd_t cmd, input logic [63:0] addr, input logic [63:0] data,
                       input logic [3:0] resp, input logic [3:0] rtag, input logic [63:0] rdata);
    bus.lsq2mem_command   = cmd;
    bus.lsq2mem_addr      = addr;
    bus.lsq2mem_data      = data;
    bus.mem2proc_response = resp;
    bus.mem2proc_tag      = rtag;
    bus.mem2proc_data     = rdata;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    drive(BUS_LOAD, 64'h100, 64'h1, 4'd3, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_NONE, 4'd0}) begin miscompares++; $display("FAIL rst_memreq got=%h exp=%h", memreq, {BUS_NONE, 4'd0}); end
    vectors++; if (bus.proc2mem_addr !== 64'h0) begin miscompares++; $display("FAIL rst_addr got=%h exp=0", bus.proc2mem_addr); end
    vectors++; if (rsp !== 69'h0) begin miscompares++; $display("FAIL rst_rsp got=%h exp=0", rsp); end
    tick(); tick();
    reset = 1'b0;
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (st_ack !== 5'h0 || rsp !== 69'h0) begin miscompares++; $display("FAIL rst_idle got=%h/%h exp=0/0", st_ack, rsp); end
`ifdef DCACHE_STATS_EN
    vectors++; if ({hit_cnt, miss_cnt} !== 64'h0) begin miscompares++; $display("FAIL rst_stats got=%h exp=0", {hit_cnt, miss_cnt}); end
`endif
    tick();
  endtask

  task automatic test_load_miss_fill();
    drive(BUS_LOAD, 64'h100, 64'h0, 4'd3, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd3}) begin miscompares++; $display("FAIL miss_fwd got=%h exp=%h", memreq, {BUS_LOAD, 4'd3}); end
    vectors++; if (bus.proc2mem_addr !== 64'h100) begin miscompares++; $display("FAIL miss_addr got=%h exp=100", bus.proc2mem_addr); end
    vectors++; if (bus.dcache2lsq_valid !== 1'b0) begin miscompares++; $display("FAIL miss_valid got=%b exp=0", bus.dcache2lsq_valid); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd3, 64'hDEAD);
    vectors++; if (rsp !== 69'h0) begin miscompares++; $display("FAIL ret_same_cycle got=%h exp=0", rsp); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd3, 64'hDEAD}) begin miscompares++; $display("FAIL ret_deliver got=%h exp=%h", rsp, {1'b1, 4'd3, 64'hDEAD}); end
    tick();
    drive(BUS_LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'hDEAD}) begin miscompares++; $display("FAIL fill_hit got=%h exp=%h", rsp, {1'b1, 4'd0, 64'hDEAD}); end
    vectors++; if (bus.proc2mem_command !== BUS_NONE) begin miscompares++; $display("FAIL hit_nocmd got=%0d exp=0", bus.proc2mem_command); end
    tick();
  endtask

  task automatic test_store();
    drive(BUS_STORE, 64'h100, 64'h55, 4'd5, 4'd0, 64'h0);
    vectors++; if (st_ack !== {1'b1, 4'd5}) begin miscompares++; $display("FAIL st_ack got=%h exp=15", st_ack); end
    vectors++; if (bus.proc2mem_command !== BUS_STORE || bus.proc2mem_data !== 64'h55) begin miscompares++; $display("FAIL st_bus got=%0d/%h exp=2/55", bus.proc2mem_command, bus.proc2mem_data); end
    tick();
    drive(BUS_LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'h55}) begin miscompares++; $display("FAIL st_hit got=%h exp=%h", rsp, {1'b1, 4'd0, 64'h55}); end
    tick();
    drive(BUS_STORE, 64'h100, 64'h77, 4'd0, 4'd0, 64'h0);
    vectors++; if (st_ack !== {1'b1, 4'd0}) begin miscompares++; $display("FAIL st_refused got=%h exp=10", st_ack); end
    tick();
    drive(BUS_LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'h55}) begin miscompares++; $display("FAIL st_refused_data got=%h exp=%h", rsp, {1'b1, 4'd0, 64'h55}); end
    tick();
  endtask

  task automatic test_rq_full();
    logic [3:0] rt [5];
    rt = '{4'd1, 4'd2, 4'd4, 4'd6, 4'd7};
    for (int i = 0; i < 4; i++) begin
      drive(BUS_LOAD, 64'h1008 + 64'(8 * i), 64'h0, rt[i], 4'd0, 64'h0);
      vectors++; if (memreq !== {BUS_LOAD, rt[i]}) begin miscompares++; $display("FAIL rq_miss%0d got=%h exp=%h", i, memreq, {BUS_LOAD, rt[i]}); end
      tick();
    end
    drive(BUS_LOAD, 64'h1028, 64'h0, 4'd7, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_NONE, 4'd0}) begin miscompares++; $display("FAIL rq_cap got=%h exp=00", memreq); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd1, 64'hA1);
    tick();
    drive(BUS_LOAD, 64'h1028, 64'h0, 4'd7, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd1, 64'hA1} || memreq !== 6'h0) begin miscompares++; $display("FAIL rq_deliver_stall got=%h/%h exp=%h/00", rsp, memreq, {1'b1, 4'd1, 64'hA1}); end
    tick();
    drive(BUS_LOAD, 64'h1028, 64'h0, 4'd7, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd7}) begin miscompares++; $display("FAIL rq_retry got=%h exp=%h", memreq, {BUS_LOAD, 4'd7}); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, rt[1], 64'hA0 + 64'(rt[1]));
    tick();
    for (int i = 2; i < 5; i++) begin
      drive(BUS_NONE, 64'h0, 64'h0, 4'd0, rt[i], 64'hA0 + 64'(rt[i]));
      vectors++; if (rsp !== {1'b1, rt[i-1], 64'hA0 + 64'(rt[i-1])}) begin miscompares++; $display("FAIL rq_pushpop%0d got=%h exp=%h", i, rsp, {1'b1, rt[i-1], 64'hA0 + 64'(rt[i-1])}); end
      tick();
    end
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd7, 64'hA7}) begin miscompares++; $display("FAIL rq_last got=%h exp=%h", rsp, {1'b1, 4'd7, 64'hA7}); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== 69'h0) begin miscompares++; $display("FAIL rq_empty got=%h exp=0", rsp); end
    tick();
    drive(BUS_LOAD, 64'h1008, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'hA1}) begin miscompares++; $display("FAIL rq_fill_hit got=%h exp=%h", rsp, {1'b1, 4'd0, 64'hA1}); end
    tick();
  endtask

  task automatic test_store_vs_miss();
    drive(BUS_LOAD, 64'h200, 64'h0, 4'd2, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd2}) begin miscompares++; $display("FAIL svm_miss got=%h exp=%h", memreq, {BUS_LOAD, 4'd2}); end
    tick();
    drive(BUS_STORE, 64'h200, 64'h99, 4'd8, 4'd0, 64'h0);
    vectors++; if (st_ack !== {1'b1, 4'd8}) begin miscompares++; $display("FAIL svm_st got=%h exp=18", st_ack); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd2, 64'hBAD);
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd2, 64'hBAD}) begin miscompares++; $display("FAIL svm_deliver got=%h exp=%h", rsp, {1'b1, 4'd2, 64'hBAD}); end
    tick();
    drive(BUS_LOAD, 64'h100, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'h55}) begin miscompares++; $display("FAIL svm_nofill got=%h exp=%h", rsp, {1'b1, 4'd0, 64'h55}); end
    tick();
    drive(BUS_LOAD, 64'h200, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (bus.proc2mem_command !== BUS_LOAD || bus.dcache2lsq_valid !== 1'b0) begin miscompares++; $display("FAIL svm_still_miss got=%0d/%b exp=1/0", bus.proc2mem_command, bus.dcache2lsq_valid); end
    tick();
  endtask

  task automatic test_back_to_back();
    drive(BUS_LOAD, 64'h300, 64'h0, 4'd9, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd9}) begin miscompares++; $display("FAIL b2b_miss got=%h exp=%h", memreq, {BUS_LOAD, 4'd9}); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd9, 64'hF00);
    tick();
    drive(BUS_STORE, 64'h300, 64'h42, 4'd10, 4'd0, 64'h0);
    vectors++; if (st_ack !== {1'b1, 4'd10} || bus.dcache2lsq_valid !== 1'b0) begin miscompares++; $display("FAIL b2b_hold got=%h/%b exp=1a/0", st_ack, bus.dcache2lsq_valid); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd9, 64'hF00}) begin miscompares++; $display("FAIL b2b_deliver got=%h exp=%h", rsp, {1'b1, 4'd9, 64'hF00}); end
    tick();
    drive(BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'h42}) begin miscompares++; $display("FAIL b2b_st_over_fill got=%h exp=%h", rsp, {1'b1, 4'd0, 64'h42}); end
    tick();
    drive(BUS_LOAD, 64'h400, 64'h0, 4'd11, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd11}) begin miscompares++; $display("FAIL same_miss got=%h exp=%h", memreq, {BUS_LOAD, 4'd11}); end
    tick();
    drive(BUS_STORE, 64'h400, 64'h66, 4'd12, 4'd11, 64'h1234);
    vectors++; if (st_ack !== {1'b1, 4'd12}) begin miscompares++; $display("FAIL same_st got=%h exp=1c", st_ack); end
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd11, 64'h1234}) begin miscompares++; $display("FAIL same_deliver got=%h exp=%h", rsp, {1'b1, 4'd11, 64'h1234}); end
    tick();
    drive(BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== {1'b1, 4'd0, 64'h42}) begin miscompares++; $display("FAIL same_store_wins got=%h exp=%h", rsp, {1'b1, 4'd0, 64'h42}); end
    tick();
`ifdef DCACHE_STATS_EN
    vectors++; if (hit_cnt !== 32'd7) begin miscompares++; $display("FAIL stats_hit got=%0d exp=7", hit_cnt); end
    vectors++; if (miss_cnt !== 32'd9) begin miscompares++; $display("FAIL stats_miss got=%0d exp=9", miss_cnt); end
`endif
  endtask

  task automatic test_reset_mid_miss();
    drive(BUS_LOAD, 64'h500, 64'h0, 4'd13, 4'd0, 64'h0);
    vectors++; if (memreq !== {BUS_LOAD, 4'd13}) begin miscompares++; $display("FAIL rmm_miss got=%h exp=%h", memreq, {BUS_LOAD, 4'd13}); end
    tick();
    reset = 1'b1;
    #2;
    reset = 1'b0;
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd13, 64'hEE);
    tick();
    drive(BUS_NONE, 64'h0, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (rsp !== 69'h0) begin miscompares++; $display("FAIL rmm_dropped got=%h exp=0", rsp); end
    tick();
    drive(BUS_LOAD, 64'h300, 64'h0, 4'd0, 4'd0, 64'h0);
    vectors++; if (bus.proc2mem_command !== BUS_LOAD || bus.dcache2lsq_valid !== 1'b0) begin miscompares++; $display("FAIL rmm_invalidated got=%0d/%b exp=1/0", bus.proc2mem_command, bus.dcache2lsq_valid); end
`ifdef DCACHE_STATS_EN
    vectors++; if ({hit_cnt, miss_cnt} !== 64'h0) begin miscompares++; $display("FAIL rmm_stats got=%h exp=0", {hit_cnt, miss_cnt}); end
`endif
    tick();
  endtask

  initial begin
    test_reset();
    test_load_miss_fill();
    test_store();
    test_rq_full();
    test_store_vs_miss();
    test_back_to_back();
    test_reset_mid_miss();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
